simon_param_core: RTL and testbench
===================================

Name: simon_param_core

Overview:
- Iterative SIMON block cipher core for every standard block/key size, selected by parameters. It replaces the fixed 48/96 core.
- Expands the key once into a round-key register file. It then encrypts or decrypts any number of blocks against that stored schedule, one round per clock.
- Uses the same newX/ldX/doneX handshake as the existing cipher cores, so benches and top levels drop in unchanged.

Parameters:
- N, 24, word size in bits; legal values 16, 24, 32, 48, 64; block is 2N.
- M, 4, key words; legal values 2, 3, 4; key is M*N.
- T, 36, round count; must match the standard value for the (N,M) pair.
- Z, 1, z-sequence index 0..4; must match the standard value for the (N,M) pair.

Ports:
- clk  in  1  clock
- nR  in  1  asynchronous active-low reset
- newKey  in  1  key load request (level)
- key  in  M*N  key; word i at bits [i*N +: N]; word 0 = k0
- ldKey  out  1  key request accepted; held until newKey sampled low
- doneKey  out  1  round keys valid
- newData  in  1  block request (level)
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with newData
- plain  in  2N  input block; x = upper N bits, y = lower N bits
- ldData  out  1  block request accepted; held until newData sampled low
- doneData  out  1  cipher valid; held until readData sampled high
- readData  in  1  consumer has taken the cipher output
- cipher  out  2N  result block

Behaviour:
- Reset (async, nR=0): all outputs 0, both FSMs go to IDLE, round-key file cleared.
- Legal parameter pairs are enforced at elaboration. An illegal (N,M,T,Z) combination is a fatal error.
- Request edge rule: newX is accepted only when ldX=0. ldX is set on acceptance and cleared on the first edge where newX=0. A held request never retriggers.
- Key FSM (KIDLE, KEXP):
  - Accept newKey in KIDLE when the data FSM is IDLE or DONE and not accepting newData on that edge.
  - On acceptance: rk[0..M-1] <= key words, doneKey <= 0, i <= M, state <= KEXP.
  - KEXP computes one key per edge:
    - tmp = ror(rk[i-1],3); if M==4 then tmp ^= rk[i-3]
    - tmp ^= ror(tmp,1)
    - rk[i] = ~rk[i-M] ^ tmp ^ z[Z][(i-M) mod 62] ^ 3
  - After rk[T-1] is written: doneKey <= 1, state <= KIDLE. doneKey rises T-M+1 edges after acceptance.
  - A newKey arriving during KEXP is ignored until KIDLE.
- Data FSM (IDLE, RUN, DONE):
  - Accept newData in IDLE only when doneKey=1. Otherwise the request waits; it is not dropped.
  - If doneKey=1 and both newKey and newData are pending, data wins.
  - On acceptance: latch the mode. Encrypt loads (x,y) = plain. Decrypt loads (x,y) = (plain.y, plain.x). Round counter r <= 0, state <= RUN.
  - RUN, one round per edge: (x,y) <= (y ^ f(x) ^ k, x), where f(x) = (rol(x,1) & rol(x,8)) ^ rol(x,2).
  - Round key k = rk[r] for encrypt, rk[T-1-r] for decrypt.
  - After T rounds: state <= DONE, doneData <= 1. doneData rises T+1 edges after newData is accepted.
- Output: cipher = {x,y} for encrypt and {y,x} for decrypt. It is registered and stable while doneData=1. Outside DONE its value is don't-care, 0 after reset.
- DONE to IDLE: on the edge readData is sampled high, doneData <= 0 and state <= IDLE.
- A newKey accepted during DONE does not disturb the cipher output.
- Mid-operation reset: abort immediately; doneKey=0, so a fresh key load is required.
- Rotations are modulo N. The z bit index wraps mod 62.

Decomposition:
- Package simon_pkg:
  - 5x62-bit z-sequence constants
  - function giving the legal T and Z for each (N,M)
  - rol/ror functions parametrised by N
  - FSM state enums
- Sub-module simon_key_sched: key FSM, round-key file, read port indexed by round. The top level holds the data FSM and the round datapath.

Test Plan:
- 48/96 default: key 1a19181211100a0908020100, encrypt 72696320646e -> 6e06a5acf156. doneKey rises 33 edges after newKey is accepted; doneData rises 37 edges after newData is accepted.
- Same key, decrypt 6e06a5acf156 -> 72696320646e. Then loop encrypt/decrypt 4 times with no key reload; every pass matches.
- N=16,M=4,T=32,Z=0: key 1918111009080100, plain 65656877 -> c69be9bb. N=32,M=4,T=44,Z=3: key 1b1a1918131211100b0a090803020100, plain 656b696c20646e75 -> 44c8fc20b9dfa07a.
- Request rules:
  - newData before doneKey -> ldData stays 0 until doneKey=1, then a correct result.
  - newData held high through completion -> exactly one block processed.
  - readData held low -> doneData and cipher stay stable for 100 cycles.
- Pull nR low mid-KEXP and mid-RUN -> all outputs 0 asynchronously. Reload the key and check scenario 1 passes again.
- In DONE, newKey with a different key -> cipher unchanged. After readData, the next block uses the new schedule.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: z-sequences, legal-size lookup, rotations and FSM
// encodings shared by the parametrised SIMON cipher core.
package simon_pkg;

  localparam logic [61:0] Z0 =
    62'b1111101000_1001010110_0001110011_0111110100_0100101011_0000111001_10;
  localparam logic [61:0] Z1 =
    62'b1000111011_1110010011_0000101101_0100011101_1111001001_1000010110_10;
  localparam logic [61:0] Z2 =
    62'b1010111101_1100000011_0100100110_0010100001_0001111110_0101101100_11;
  localparam logic [61:0] Z3 =
    62'b1101101110_1011000110_0101111000_0001001000_1010011100_1101000011_11;
  localparam logic [61:0] Z4 =
    62'b1101000111_1001101011_0110001000_0001011100_0011001010_0100111011_11;

  typedef enum logic {
    KIDLE,
    KEXP
  } kstate_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dstate_e;

  function automatic int legal_t(input int n, input int m);
    if (n == 16 && m == 4) return 32;
    if (n == 24 && m == 3) return 36;
    if (n == 24 && m == 4) return 36;
    if (n == 32 && m == 3) return 42;
    if (n == 32 && m == 4) return 44;
    if (n == 48 && m == 2) return 52;
    if (n == 48 && m == 3) return 54;
    if (n == 64 && m == 2) return 68;
    if (n == 64 && m == 3) return 69;
    if (n == 64 && m == 4) return 72;
    return 0;
  endfunction

  function automatic int legal_z(input int n, input int m);
    if (n == 16 && m == 4) return 0;
    if (n == 24 && m == 3) return 0;
    if (n == 24 && m == 4) return 1;
    if (n == 32 && m == 3) return 2;
    if (n == 32 && m == 4) return 3;
    if (n == 48 && m == 2) return 2;
    if (n == 48 && m == 3) return 3;
    if (n == 64 && m == 2) return 2;
    if (n == 64 && m == 3) return 3;
    if (n == 64 && m == 4) return 4;
    return -1;
  endfunction

  // Sequence bit j is the j-th character of the published string (MSB first).
  function automatic logic z_bit(input int zi, input int j);
    logic [61:0] s;
    logic [61:0] t;
    unique case (zi)
      0: s = Z0;
      1: s = Z1;
      2: s = Z2;
      3: s = Z3;
      default: s = Z4;
    endcase
    t = s << (j % 62);
    return t[61];
  endfunction

  // Rotations on an n-bit word carried in the low bits of 64.
  function automatic logic [63:0] rol(
    input logic [63:0] x,
    input int          n,
    input int          s
  );
    logic [63:0] m;
    m = {64{1'b1}} >> (64 - n);
    return ((x << s) | ((x & m) >> (n - s))) & m;
  endfunction

  function automatic logic [63:0] ror(
    input logic [63:0] x,
    input int          n,
    input int          s
  );
    return rol(x, n, n - s);
  endfunction

endpackage

// File: rtl/simon_param_core_key_sched.sv
// simon_key_sched: expands an M-word key into T round keys,
// one per clock, and serves them to the round datapath.
module simon_key_sched
  import simon_pkg::*;
#(
  parameter int N = 24,
  parameter int M = 4,
  parameter int T = 36,
  parameter int Z = 1
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 new_key_i,
  input  logic [M*N-1:0]       key_i,
  input  logic                 data_hold_i,
  input  logic [$clog2(T)-1:0] rd_idx_i,
  output logic [N-1:0]         rd_key_o,
  output logic                 ld_key_o,
  output logic                 done_key_o
);
  localparam int KW = $clog2(T);
  localparam int CW = $clog2(T + 1);

  kstate_e             st_q, st_d;
  logic [T-1:0][N-1:0] rk_q, rk_d;
  logic [CW-1:0]       i_q, i_d;
  logic                ld_q, done_q;
  logic                acc, step, last;
  logic [N-1:0]        km1, km3, kmm, tmp, rk_new;
  logic                zb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= KIDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      KIDLE:   if (acc) st_d = KEXP;
      KEXP:    if (last) st_d = KIDLE;
      default: st_d = KIDLE;
    endcase
  end

  always_comb begin
    acc  = (st_q == KIDLE) && new_key_i && !ld_q && !data_hold_i;
    step = (st_q == KEXP) && (i_q != CW'(T));
    last = (st_q == KEXP) && (i_q == CW'(T));
  end

  always_comb begin
    km1    = rk_q[KW'(i_q - CW'(1))];
    km3    = rk_q[KW'(i_q - CW'(3))];
    kmm    = rk_q[KW'(i_q - CW'(M))];
    tmp    = N'(ror(64'(km1), N, 3));
    if (M == 4) tmp = tmp ^ km3;
    tmp    = tmp ^ N'(ror(64'(tmp), N, 1));
    zb     = z_bit(Z, int'(i_q) - M);
    rk_new = ~kmm ^ tmp ^ N'(3) ^ N'(zb);
  end

  always_comb begin
    rk_d = rk_q;
    i_d  = i_q;
    if (acc) begin
      for (int j = 0; j < M; j++) rk_d[j] = key_i[j*N +: N];
      i_d = CW'(M);
    end else if (step) begin
      rk_d[KW'(i_q)] = rk_new;
      i_d            = i_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_q   <= '0;
      i_q    <= '0;
      ld_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rk_q <= rk_d;
      i_q  <= i_d;
      if (acc)             ld_q <= 1'b1;
      else if (!new_key_i) ld_q <= 1'b0;
      if (acc)       done_q <= 1'b0;
      else if (last) done_q <= 1'b1;
    end
  end

  assign rd_key_o   = rk_q[rd_idx_i];
  assign ld_key_o   = ld_q;
  assign done_key_o = done_q;

endmodule

// File: rtl/simon_param_core.sv
// simon_param_core: iterative SIMON encrypt/decrypt, one round per
// clock, against a stored round-key schedule.
module simon_param_core
  import simon_pkg::*;
#(
  parameter int N = 24,
  parameter int M = 4,
  parameter int T = 36,
  parameter int Z = 1
)(
  input  logic           clk,
  input  logic           nR,
  input  logic           newKey,
  input  logic [M*N-1:0] key,
  output logic           ldKey,
  output logic           doneKey,
  input  logic           newData,
  input  logic           enc_dec,
  input  logic [2*N-1:0] plain,
  output logic           ldData,
  output logic           doneData,
  input  logic           readData,
  output logic [2*N-1:0] cipher
);
  localparam int KW = $clog2(T);
  localparam int CW = $clog2(T + 1);

  if (T != legal_t(N, M) || Z != legal_z(N, M)) begin : g_bad_cfg
    $fatal(1, "simon_param_core: illegal N/M/T/Z combination");
  end

  dstate_e        st_q, st_d;
  logic [N-1:0]   x_q, x_d, y_q, y_d;
  logic [CW-1:0]  r_q, r_d;
  logic           enc_q, ld_q, done_q;
  logic [2*N-1:0] ct_q;
  logic           done_key, data_acc, data_hold;
  logic           step, fin, clr;
  logic [KW-1:0]  rd_idx;
  logic [N-1:0]   rk, fx;

  simon_key_sched #(
    .N(N), .M(M), .T(T), .Z(Z)
  ) u_ks (
    .clk        (clk),
    .rst_n      (nR),
    .new_key_i  (newKey),
    .key_i      (key),
    .data_hold_i(data_hold),
    .rd_idx_i   (rd_idx),
    .rd_key_o   (rk),
    .ld_key_o   (ldKey),
    .done_key_o (done_key)
  );

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (1'b1)
      data_acc: st_d = RUN;
      fin:      st_d = DONE;
      clr:      st_d = IDLE;
      default:  st_d = st_q;
    endcase
  end

  // Data outranks a pending key load so the schedule never moves under a block.
  always_comb begin
    data_acc  = (st_q == IDLE) && newData && !ld_q && done_key;
    data_hold = (st_q == RUN) || data_acc;
    step      = (st_q == RUN) && (r_q != CW'(T));
    fin       = (st_q == RUN) && (r_q == CW'(T));
    clr       = (st_q == DONE) && readData;
  end

  assign rd_idx = enc_q ? KW'(r_q) : KW'(CW'(T - 1) - r_q);
  assign fx = (N'(rol(64'(x_q), N, 1)) & N'(rol(64'(x_q), N, 8)))
            ^ N'(rol(64'(x_q), N, 2));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    r_d = r_q;
    if (data_acc) begin
      x_d = enc_dec ? plain[2*N-1:N] : plain[N-1:0];
      y_d = enc_dec ? plain[N-1:0]   : plain[2*N-1:N];
      r_d = '0;
    end else if (step) begin
      x_d = y_q ^ fx ^ rk;
      y_d = x_q;
      r_d = r_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      x_q    <= '0;
      y_q    <= '0;
      r_q    <= '0;
      enc_q  <= 1'b0;
      ld_q   <= 1'b0;
      done_q <= 1'b0;
      ct_q   <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      r_q <= r_d;
      if (data_acc)      enc_q <= enc_dec;
      if (data_acc)      ld_q <= 1'b1;
      else if (!newData) ld_q <= 1'b0;
      if (fin)      done_q <= 1'b1;
      else if (clr) done_q <= 1'b0;
      if (fin) ct_q <= enc_q ? {x_q, y_q} : {y_q, x_q};
    end
  end

  assign doneKey  = done_key;
  assign ldData   = ld_q;
  assign doneData = done_q;
  assign cipher   = ct_q;

endmodule

// File: tb/tb_simon_param_core.sv
// tb_simon_param_core: directed known-answer and handshake checks
// for three SIMON sizes (32/64, 48/96, 64/128).
module tb_simon_param_core;

  localparam logic [95:0]  K48 = 96'h1a1918121110_0a0908020100;
  localparam logic [47:0]  P48 = 48'h72696320646e;
  localparam logic [47:0]  C48 = 48'h6e06a5acf156;
  localparam logic [95:0]  K2  = 96'h0123456789abcdeffedcba98;
  localparam logic [63:0]  K32 = 64'h1918111009080100;
  localparam logic [31:0]  P32 = 32'h65656877;
  localparam logic [31:0]  C32 = 32'hc69be9bb;
  localparam logic [127:0] K64 = 128'h1b1a1918131211100b0a090803020100;
  localparam logic [63:0]  P64 = 64'h656b696c20646e75;
  localparam logic [63:0]  C64 = 64'h44c8fc20b9dfa07a;
  localparam logic [61:0]  ZB1 =
    62'b1000111011_1110010011_0000101101_0100011101_1111001001_1000010110_10;

  typedef struct {
    int           u;
    logic         enc;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic nR  = 1'b0;
  always #5 clk = ~clk;

  logic nk[3], nd[3], ed[3], rd[3];
  logic lk[3], dk[3], ldd[3], dd[3];
  logic [95:0]  k48;
  logic [63:0]  k32;
  logic [127:0] k64;
  logic [47:0]  p48, c48;
  logic [31:0]  p32, c32;
  logic [63:0]  p64, c64;
  int nvec = 0;
  int nerr = 0;

  simon_param_core u48 (
    .clk(clk), .nR(nR), .newKey(nk[0]), .key(k48), .ldKey(lk[0]),
    .doneKey(dk[0]), .newData(nd[0]), .enc_dec(ed[0]), .plain(p48),
    .ldData(ldd[0]), .doneData(dd[0]), .readData(rd[0]), .cipher(c48)
  );

  simon_param_core #(.N(16), .M(4), .T(32), .Z(0)) u32 (
    .clk(clk), .nR(nR), .newKey(nk[1]), .key(k32), .ldKey(lk[1]),
    .doneKey(dk[1]), .newData(nd[1]), .enc_dec(ed[1]), .plain(p32),
    .ldData(ldd[1]), .doneData(dd[1]), .readData(rd[1]), .cipher(c32)
  );

  simon_param_core #(.N(32), .M(4), .T(44), .Z(3)) u64 (
    .clk(clk), .nR(nR), .newKey(nk[2]), .key(k64), .ldKey(lk[2]),
    .doneKey(dk[2]), .newData(nd[2]), .enc_dec(ed[2]), .plain(p64),
    .ldData(ldd[2]), .doneData(dd[2]), .readData(rd[2]), .cipher(c64)
  );

  function automatic logic [23:0] rl24(input logic [23:0] v, input int s);
    logic [47:0] w;
    w = {v, v} >> (24 - s);
    return w[23:0];
  endfunction

  // Independent SIMON48/96 reference used for the second key.
  function automatic logic [47:0] m48(input logic [95:0] k, input logic [47:0] p);
    logic [23:0] rk[36];
    logic [23:0] x, y, t;
    for (int i = 0; i < 4; i++) rk[i] = k[i*24 +: 24];
    for (int i = 4; i < 36; i++) begin
      t     = rl24(rk[i-1], 21) ^ rk[i-3];
      t     = t ^ rl24(t, 23);
      rk[i] = ~rk[i-4] ^ t ^ {23'd0, ZB1[65-i]} ^ 24'd3;
    end
    x = p[47:24];
    y = p[23:0];
    for (int i = 0; i < 36; i++) begin
      t = x;
      x = y ^ ((rl24(x, 1) & rl24(x, 8)) ^ rl24(x, 2)) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] ctv(input int u);
    case (u)
      0:       return 128'(c48);
      1:       return 128'(c32);
      default: return 128'(c64);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic set_k(input int u, input logic [127:0] k);
    case (u)
      0:       k48 = k[95:0];
      1:       k32 = k[63:0];
      default: k64 = k;
    endcase
  endtask

  task automatic set_p(input int u, input logic [127:0] p);
    case (u)
      0:       p48 = p[47:0];
      1:       p32 = p[31:0];
      default: p64 = p[63:0];
    endcase
  endtask

  task automatic load_key(input int u, input logic [127:0] k, output int lat);
    int n;
    @(negedge clk);
    set_k(u, k);
    nk[u] = 1'b1;
    n = 0;
    while (!lk[u] && n < 300) begin @(negedge clk); n++; end
    nk[u] = 1'b0;
    lat = 0;
    while (!dk[u] && lat < 300) begin @(negedge clk); lat++; end
  endtask

  task automatic run_blk(input int u, input logic enc, input logic [127:0] p,
                         output logic [127:0] ct, output int lat);
    int n;
    @(negedge clk);
    set_p(u, p);
    ed[u] = enc;
    nd[u] = 1'b1;
    n = 0;
    while (!ldd[u] && n < 300) begin @(negedge clk); n++; end
    nd[u] = 1'b0;
    lat = 0;
    while (!dd[u] && lat < 300) begin @(negedge clk); lat++; end
    ct = ctv(u);
    rd[u] = 1'b1;
    @(negedge clk);
    rd[u] = 1'b0;
  endtask

  task automatic rst_check(input string nm);
    #2 nR = 1'b0;
    #1 chk(nm, 128'({lk[0], dk[0], ldd[0], dd[0], c48}), 128'd0);
    @(negedge clk);
    nR = 1'b1;
  endtask

  initial begin
    vec_t         tv[6];
    int           lat, n, bad;
    logic [127:0] ct;

    for (int i = 0; i < 3; i++) begin
      nk[i] = 1'b0; nd[i] = 1'b0; ed[i] = 1'b0; rd[i] = 1'b0;
    end
    k48 = '0; k32 = '0; k64 = '0; p48 = '0; p32 = '0; p64 = '0;

    tv[0] = '{0, 1'b1, 128'(P48), 128'(C48), 37};
    tv[1] = '{0, 1'b0, 128'(C48), 128'(P48), 37};
    tv[2] = '{1, 1'b1, 128'(P32), 128'(C32), 33};
    tv[3] = '{1, 1'b0, 128'(C32), 128'(P32), 33};
    tv[4] = '{2, 1'b1, 128'(P64), 128'(C64), 45};
    tv[5] = '{2, 1'b0, 128'(C64), 128'(P64), 45};

    repeat (2) @(negedge clk);
    chk("reset outputs", 128'({lk[0], dk[0], ldd[0], dd[0], c48}), 128'd0);
    nR = 1'b1;

    load_key(0, 128'(K48), lat);
    chk("doneKey latency 48/96", 128'(lat), 128'd33);
    load_key(1, 128'(K32), lat);
    chk("doneKey latency 32/64", 128'(lat), 128'd29);
    load_key(2, K64, lat);
    chk("doneKey latency 64/128", 128'(lat), 128'd41);

    foreach (tv[i]) begin
      run_blk(tv[i].u, tv[i].enc, tv[i].pt, ct, lat);
      chk($sformatf("vec%0d result", i), ct, tv[i].ct);
      chk($sformatf("vec%0d latency", i), 128'(lat), 128'(tv[i].lat));
    end

    for (int p = 0; p < 4; p++) begin
      run_blk(0, 1'b1, 128'(P48), ct, lat);
      chk($sformatf("loop%0d enc", p), ct, 128'(C48));
      run_blk(0, 1'b0, 128'(C48), ct, lat);
      chk($sformatf("loop%0d dec", p), ct, 128'(P48));
    end

    // newData raised before the key is ready must wait for doneKey.
    @(negedge clk); nR = 1'b0;
    @(negedge clk); nR = 1'b1;
    @(negedge clk);
    set_p(0, 128'(P48)); ed[0] = 1'b1; nd[0] = 1'b1;
    set_k(0, 128'(K48)); nk[0] = 1'b1;
    bad = 0; n = 0;
    while (!dk[0] && n < 300) begin
      @(negedge clk); n++;
      if (lk[0]) nk[0] = 1'b0;
      if (ldd[0] && !dk[0]) bad++;
    end
    chk("early newData held off", 128'(bad), 128'd0);
    n = 0;
    while (!ldd[0] && n < 300) begin @(negedge clk); n++; end
    nd[0] = 1'b0;
    n = 0;
    while (!dd[0] && n < 300) begin @(negedge clk); n++; end
    chk("early newData result", 128'(c48), 128'(C48));
    rd[0] = 1'b1; @(negedge clk); rd[0] = 1'b0;

    // newData held high through completion: exactly one block.
    set_p(0, 128'(P48)); ed[0] = 1'b1; nd[0] = 1'b1;
    n = 0;
    while (!dd[0] && n < 300) begin @(negedge clk); n++; end
    chk("held newData result", 128'(c48), 128'(C48));
    rd[0] = 1'b1; @(negedge clk); rd[0] = 1'b0;
    bad = 0;
    repeat (60) begin @(negedge clk); if (dd[0] || !ldd[0]) bad++; end
    chk("held newData single block", 128'(bad), 128'd0);
    nd[0] = 1'b0;

    // readData held low: output must hold.
    @(negedge clk);
    set_p(0, 128'(C48)); ed[0] = 1'b0; nd[0] = 1'b1;
    n = 0;
    while (!ldd[0] && n < 300) begin @(negedge clk); n++; end
    nd[0] = 1'b0;
    n = 0;
    while (!dd[0] && n < 300) begin @(negedge clk); n++; end
    bad = 0;
    repeat (100) begin @(negedge clk); if (!dd[0] || c48 !== P48) bad++; end
    chk("done held 100 cycles", 128'(bad), 128'd0);
    rd[0] = 1'b1; @(negedge clk); rd[0] = 1'b0;

    // New key while DONE: output undisturbed, next block uses new key.
    set_p(0, 128'(P48)); ed[0] = 1'b1; nd[0] = 1'b1;
    n = 0;
    while (!ldd[0] && n < 300) begin @(negedge clk); n++; end
    nd[0] = 1'b0;
    n = 0;
    while (!dd[0] && n < 300) begin @(negedge clk); n++; end
    set_k(0, 128'(K2)); nk[0] = 1'b1;
    n = 0;
    while (!lk[0] && n < 300) begin @(negedge clk); n++; end
    nk[0] = 1'b0;
    bad = 0;
    repeat (40) begin @(negedge clk); if (!dd[0] || c48 !== C48) bad++; end
    chk("cipher stable across newKey", 128'(bad), 128'd0);
    chk("new key expanded in DONE", 128'(dk[0]), 128'd1);
    rd[0] = 1'b1; @(negedge clk); rd[0] = 1'b0;
    run_blk(0, 1'b1, 128'(P48), ct, lat);
    chk("second key encrypt", ct, 128'(m48(K2, P48)));

    // Asynchronous reset in the middle of key expansion.
    @(negedge clk);
    set_k(0, 128'(K48)); nk[0] = 1'b1;
    repeat (10) @(negedge clk);
    nk[0] = 1'b0;
    rst_check("reset mid-KEXP");
    load_key(0, 128'(K48), lat);
    chk("reload latency", 128'(lat), 128'd33);
    run_blk(0, 1'b1, 128'(P48), ct, lat);
    chk("after KEXP reset result", ct, 128'(C48));

    // Asynchronous reset in the middle of a block.
    @(negedge clk);
    set_p(0, 128'(P48)); ed[0] = 1'b1; nd[0] = 1'b1;
    repeat (10) @(negedge clk);
    nd[0] = 1'b0;
    rst_check("reset mid-RUN");
    repeat (3) @(negedge clk);
    chk("doneKey low after reset", 128'(dk[0]), 128'd0);
    load_key(0, 128'(K48), lat);
    run_blk(0, 1'b1, 128'(P48), ct, lat);
    chk("after RUN reset result", ct, 128'(C48));
    chk("after RUN reset latency", 128'(lat), 128'd37);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
